dll_lock_monitor: RTL and testbench

//   Lock detector and frequency meter for the digital locked loop. Runs on the DLL output clock and

---
 rtl/dll_pkg.sv | 16 +
 rtl/osc_edge_sync.sv | 29 ++
 rtl/dll_lock_monitor.sv | 152 +++++++++++++++
 tb/tb_dll_lock_monitor.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dll_pkg.sv
// Shared definitions for the DLL lock monitor and the dll_controller benches:
// FSM state encoding and the default measurement parameters.
package dll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } dll_state_t;

    localparam int DLL_CNT_W    = 8;
    localparam int DLL_TOL      = 1;
    localparam int DLL_LOCK_CNT = 8;

endpackage

// File: rtl/osc_edge_sync.sv
// Brings the asynchronous reference oscillator into the DLL clock domain and
// produces a one-cycle pulse on each synchronized rising edge.
module osc_edge_sync (
    input  logic clock,
    input  logic resetb,
    input  logic osc,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic delayed;

    // Two-flop synchronizer followed by a delay flop for edge detection
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            delayed <= 1'b0;
        end else begin
            sync1   <= osc;
            sync2   <= sync1;
            delayed <= sync2;
        end
    end

    assign rise = sync2 & ~delayed;

endmodule

// File: rtl/dll_lock_monitor.sv
// Lock detector and frequency meter for the DLL. Counts DLL clock cycles per
// reference-oscillator period, compares against the feedback ratio and
// tracks lock / loss of lock.
module dll_lock_monitor
    import dll_pkg::*;
#(
    parameter int CNT_W    = DLL_CNT_W,
    parameter int TOL      = DLL_TOL,
    parameter int LOCK_CNT = DLL_LOCK_CNT
) (
    input  logic                    clock,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    osc,
    input  logic [4:0]              div,
    input  logic                    lost_clr,
    output logic                    locked,
    output logic                    lock_lost,
    output logic                    meas_valid,
    output logic [CNT_W-1:0]        meas_count,
    output logic signed [CNT_W:0]   meas_err
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [RUN_W-1:0] RUN_TGT  = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_CNT - 1);

    // Period error; one extra bit so neither extreme can overflow
    function automatic logic signed [CNT_W:0] period_err(
        input logic [CNT_W-1:0] n,
        input logic [4:0]       d
    );
        period_err = signed'({1'b0, n}) - signed'((CNT_W+1)'(d));
    endfunction

    // A measurement is good only with a nonzero ratio and |err| within tolerance
    function automatic logic within_tol(
        input logic signed [CNT_W:0] e,
        input logic [4:0]            d
    );
        within_tol = (|d) && (int'(e) <= TOL) && (int'(e) >= -TOL);
    endfunction

    dll_state_t                state;
    logic                      edge_det;
    logic [CNT_W-1:0]          cnt;
    logic [RUN_W-1:0]          good_run;
    logic                      running;
    logic                      capture;
    logic signed [CNT_W:0]     cur_err;
    logic                      cur_good;

    osc_edge_sync u_sync (
        .clock  (clock),
        .resetb (resetb),
        .osc    (osc),
        .rise   (edge_det)
    );

    // A measurement closes on an osc edge or when the counter saturates (stalled osc)
    always_comb begin
        running  = (state == ST_ACQUIRE) || (state == ST_LOCKED);
        capture  = enable && running && (edge_det || (cnt == CNT_MAX));
        cur_err  = period_err(cnt, div);
        cur_good = within_tol(cur_err, div) && (cnt != CNT_MAX || edge_det)
                   && (cnt != CNT_MAX);
    end

    // Period counter: loads 1 on each edge (or timeout) and counts clocks in between
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cnt <= '0;
        end else if (!enable || state == ST_IDLE) begin
            cnt <= '0;
        end else if (state == ST_ARM) begin
            cnt <= edge_det ? CNT_ONE : '0;
        end else if (capture) begin
            cnt <= CNT_ONE;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Lock FSM with registered status, capture registers and sticky loss flag
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            good_run   <= '0;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            meas_valid <= 1'b0;
            meas_count <= '0;
            meas_err   <= '0;
        end else begin
            meas_valid <= 1'b0;
            // Clear first so a simultaneous loss below takes priority
            if (lost_clr) begin
                lock_lost <= 1'b0;
            end
            if (!enable) begin
                state    <= ST_IDLE;
                locked   <= 1'b0;
                good_run <= '0;
            end else begin
                if (capture) begin
                    meas_valid <= 1'b1;
                    meas_count <= cnt;
                    meas_err   <= cur_err;
                end
                case (state)
                    ST_IDLE: begin
                        state <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (edge_det) begin
                            state <= ST_ACQUIRE;
                        end
                    end
                    ST_ACQUIRE: begin
                        if (capture) begin
                            if (cur_good) begin
                                if (good_run == RUN_LAST) begin
                                    state    <= ST_LOCKED;
                                    locked   <= 1'b1;
                                    good_run <= RUN_TGT;
                                end else begin
                                    good_run <= good_run + 1'b1;
                                end
                            end else begin
                                good_run <= '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (capture && !cur_good) begin
                            state     <= ST_ACQUIRE;
                            locked    <= 1'b0;
                            good_run  <= '0;
                            lock_lost <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dll_lock_monitor.sv
// Scoreboard bench for dll_lock_monitor: the stimulus thread queues the
// expected measurement for each osc edge, a monitor pops and compares on
// every meas_valid.
module tb_dll_lock_monitor;

    logic              clock    = 1'b0;
    logic              resetb   = 1'b1;
    logic              enable   = 1'b0;
    logic              osc      = 1'b0;
    logic [4:0]        div      = 5'd8;
    logic              lost_clr = 1'b0;
    logic              locked;
    logic              lock_lost;
    logic              meas_valid;
    logic [7:0]        meas_count;
    logic signed [8:0] meas_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int err;
        bit lk;
        bit lost;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    dll_lock_monitor #(
        .CNT_W    (8),
        .TOL      (1),
        .LOCK_CNT (4)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .enable     (enable),
        .osc        (osc),
        .div        (div),
        .lost_clr   (lost_clr),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .meas_valid (meas_valid),
        .meas_count (meas_count),
        .meas_err   (meas_err)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Monitor: every measurement must match the next queued expectation
    always @(negedge clock) begin
        exp_t e;
        if (resetb && meas_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_meas: actual meas_valid with count %0d required none",
                         meas_count);
            end else begin
                e = sb.pop_front();
                check("meas_count", int'(meas_count), e.cnt);
                check("meas_err", int'(meas_err), e.err);
                check("meas_locked", int'(locked), int'(e.lk));
                check("meas_lock_lost", int'(lock_lost), int'(e.lost));
            end
        end
    end

    // One osc rise after 'gap' time units; the measurement it closes is 'gap'/10 clocks
    task automatic osc_edge(input int gap, input bit has_exp, input int e_cnt,
                            input int e_err, input bit e_lk, input bit e_lost);
        exp_t e;
        #(gap - 20);
        if (has_exp) begin
            e.cnt  = e_cnt;
            e.err  = e_err;
            e.lk   = e_lk;
            e.lost = e_lost;
            sb.push_back(e);
        end
        osc = 1'b1;
        #20;
        osc = 1'b0;
    endtask

    // Let the last measurement land, cycle enable, and align osc 3 units after a clock edge
    task automatic restart();
        repeat (6) @(posedge clock);
        #1 enable = 1'b0;
        repeat (2) @(posedge clock);
        #1 enable = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #3;
    endtask

    // Silent arming edge followed by four good 80-unit periods at div=8
    task automatic lock_at_80(input bit lost);
        osc_edge(80, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) osc_edge(80, 1'b1, 8, 0, (i == 4), lost);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

    initial begin
        #1 resetb = 1'b0;
        #11;
        check("rst_locked", int'(locked), 0);
        check("rst_lock_lost", int'(lock_lost), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_meas_count", int'(meas_count), 0);
        check("rst_meas_err", int'(meas_err), 0);
        @(posedge clock);
        #1 resetb = 1'b1;
        enable = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #3;

        // Acquire at exact ratio
        lock_at_80(1'b0);
        for (int i = 0; i < 2; i++) osc_edge(80, 1'b1, 8, 0, 1'b1, 1'b0);

        // +1 error is within tolerance
        restart();
        osc_edge(90, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) osc_edge(90, 1'b1, 9, 1, (i == 4), 1'b0);

        // A bad measurement in ACQUIRE restarts the good run
        restart();
        osc_edge(80, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) osc_edge(80, 1'b1, 8, 0, 1'b0, 1'b0);
        osc_edge(60, 1'b1, 6, -2, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) osc_edge(80, 1'b1, 8, 0, (i == 4), 1'b0);

        // +2 error never locks
        restart();
        osc_edge(100, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) osc_edge(100, 1'b1, 10, 2, 1'b0, 1'b0);

        // Loss of lock, relock, then clear the sticky flag
        restart();
        lock_at_80(1'b0);
        osc_edge(120, 1'b1, 12, 4, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) osc_edge(80, 1'b1, 8, 0, (i == 4), 1'b1);
        repeat (6) @(posedge clock);
        #1 lost_clr = 1'b1;
        @(posedge clock);
        #1 lost_clr = 1'b0;
        check("lost_clr_clears", int'(lock_lost), 0);

        // lost_clr coincident with a loss: set wins; held one more cycle it clears
        restart();
        lock_at_80(1'b0);
        begin
            exp_t e;
            #100;
            e.cnt = 12; e.err = 4; e.lk = 1'b0; e.lost = 1'b1;
            sb.push_back(e);
            osc = 1'b1;
            #20 osc = 1'b0;
            #4 lost_clr = 1'b1;
            #20 lost_clr = 1'b0;
            #1;
            check("race_then_clear", int'(lock_lost), 0);
        end

        // enable dropped mid-period while locked
        restart();
        lock_at_80(1'b0);
        repeat (3) @(posedge clock);
        #1 enable = 1'b0;
        @(posedge clock);
        #1;
        check("dis_locked", int'(locked), 0);
        check("dis_meas_valid", int'(meas_valid), 0);
        check("dis_meas_count_hold", int'(meas_count), 8);
        enable = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #3;
        lock_at_80(1'b0);

        // div = 0 disables lock detection
        restart();
        div = 5'd0;
        osc_edge(80, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) osc_edge(80, 1'b1, 8, 8, 1'b0, 1'b0);
        restart();
        div = 5'd8;

        // osc stall after lock: saturated measurement is a loss
        lock_at_80(1'b0);
        begin
            exp_t e;
            e.cnt = 255; e.err = 247; e.lk = 1'b0; e.lost = 1'b1;
            sb.push_back(e);
        end
        repeat (300) @(posedge clock);
        check("stall_locked", int'(locked), 0);

        // Relock with sticky flag still set, then asynchronous reset between edges
        restart();
        osc_edge(90, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) osc_edge(90, 1'b1, 9, 1, (i == 4), 1'b1);
        repeat (6) @(posedge clock);
        check("pre_reset_locked", int'(locked), 1);
        #2 resetb = 1'b0;
        #1;
        check("arst_locked", int'(locked), 0);
        check("arst_lock_lost", int'(lock_lost), 0);
        check("arst_meas_valid", int'(meas_valid), 0);
        check("arst_meas_count", int'(meas_count), 0);
        check("arst_meas_err", int'(meas_err), 0);
        check("sb_empty", sb.size(), 0);
        #20 resetb = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
